key_debounce: RTL and testbench



---
 rtl/key_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/key_debounce.sv | 102 ++++++++++
 tb/tb_key_debounce.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key front-end: FSM encoding, 50 MHz board defaults
// and a counter-width helper.
package key_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = ST_IDLE,
        PRESS_WAIT   = ST_PRESS_WAIT,
        PRESSED      = ST_PRESSED,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } key_state_e;

    localparam int DEBOUNCE_DEF = 500000;    // 10 ms at 50 MHz
    localparam int LONG_DEF     = 50000000;  // 1 s at 50 MHz

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for W asynchronous pins, with a synchronous reset value.
module sync_2ff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button front-end: synchronise the pin, debounce with a stability counter
// and emit a clean level plus press / release / long-press strobes.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE   = DEBOUNCE_DEF,
    parameter int LONG       = LONG_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CW = cnt_w(DEBOUNCE);
    localparam int HW = cnt_w(LONG);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG - 1);

    logic p, s;
    assign p = key_raw ^ ACTIVE_LOW;

    sync_2ff #(.W(1), .RST_VAL(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (p),
        .q   (s)
    );

    key_state_e    state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic          long_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            long_done   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                        hold      <= '0;
                        long_done <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    // hold keeps counting on the cycle the pin first drops
                    if (hold != HOLD_LAST) hold <= hold + HW'(1);
                    if (hold == HOLD_LAST && !long_done) begin
                        key_long  <= 1'b1;
                        long_done <= 1'b1;
                    end
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // bounce back keeps hold and long_done so nothing re-fires
                    if (s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: a reset/clean-press vector table, directed corner
// sequences and a randomized run against a run-length reference model.
module tb_key_debounce;

    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_raw = 1'b1;
    logic key_level, key_press, key_release, key_long;

    always #5 clk = ~clk;

    key_debounce #(.DEBOUNCE(D), .LONG(L), .ACTIVE_LOW(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: pressed-high pin delayed two edges, level flips after
    // D+1 consecutive samples disagreeing with it; long fires on the L-th edge
    // spent pressed with the pin still held.
    bit       m_d1, m_d2, m_prev_s, m_level;
    int       m_run, m_hold;
    bit [3:0] m_out;

    int n_press, n_rel, n_long, t_press, t_rel, t_long;

    typedef struct {
        bit       rst;
        bit       raw;
        bit [3:0] exp;  // {level, press, release, long}
    } vec_t;
    vec_t tbl[13];

    function automatic bit [3:0] dut_out();
        return {key_level, key_press, key_release, key_long};
    endfunction

    task automatic model_edge(input bit r, input bit raw);
        bit s, pr, rl, lg;
        s  = m_d2;
        pr = 1'b0;
        rl = 1'b0;
        lg = 1'b0;
        if (r) begin
            m_d1 = 0; m_d2 = 0; m_prev_s = 0; m_level = 0;
            m_run = 0; m_hold = 0;
        end else begin
            m_d2 = m_d1;
            m_d1 = raw ^ 1'b1;
            if (m_level && m_prev_s) begin
                m_hold++;
                if (m_hold == L) lg = 1'b1;
            end
            if (s != m_level) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                m_level = !m_level;
                m_run   = 0;
                if (m_level) begin
                    pr     = 1'b1;
                    m_hold = 0;
                end else begin
                    rl = 1'b1;
                end
            end
            m_prev_s = s;
        end
        m_out = {m_level, pr, rl, lg};
    endtask

    task automatic check4(input string name, input bit [3:0] want);
        n_cmp++;
        if (dut_out() !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, dut_out(), want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    task automatic clr_counts();
        n_press = 0; n_rel = 0; n_long = 0;
        t_press = -1; t_rel = -1; t_long = -1;
    endtask

    task automatic step(input bit r, input bit raw, input bit chk);
        rst     = r;
        key_raw = raw;
        @(posedge clk);
        cyc++;
        model_edge(r, raw);
        #1;
        if (key_press)   begin n_press++; t_press = cyc; end
        if (key_release) begin n_rel++;   t_rel   = cyc; end
        if (key_long)    begin n_long++;  t_long  = cyc; end
        if (chk) check4("model", m_out);
    endtask

    initial begin
        int t0;
        bit lvl;
        int len;

        // Reset with the pin toggling, then a clean press (D=4 -> press at E0+6).
        tbl[0]  = '{1'b1, 1'b1, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 4'b0000};
        tbl[2]  = '{1'b1, 1'b1, 4'b0000};
        tbl[3]  = '{1'b0, 1'b1, 4'b0000};
        tbl[4]  = '{1'b0, 1'b0, 4'b0000};
        tbl[5]  = '{1'b0, 1'b0, 4'b0000};
        tbl[6]  = '{1'b0, 1'b0, 4'b0000};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000};
        tbl[8]  = '{1'b0, 1'b0, 4'b0000};
        tbl[9]  = '{1'b0, 1'b0, 4'b0000};
        tbl[10] = '{1'b0, 1'b0, 4'b1100};
        tbl[11] = '{1'b0, 1'b0, 4'b1000};
        tbl[12] = '{1'b0, 1'b0, 4'b1000};

        clr_counts();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].raw, 1'b0);
            check4("table", tbl[i].exp);
        end

        // Long hold: exactly one key_long, L cycles after key_press.
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
        check_int("long_count", n_long, 1);
        check_int("long_delay", t_long - t_press, L);

        // Release glitch of two cycles, then a real release.
        clr_counts();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
        check_int("glitch_no_release", n_rel, 0);
        check_int("glitch_level", int'(key_level), 1);
        check_int("glitch_no_repress", n_press, 0);
        step(1'b0, 1'b1, 1'b1);
        t0 = cyc;
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1);
        check_int("release_count", n_rel, 1);
        check_int("release_delay", t_rel - t0, D + 2);

        // Bounce 0,1,0,1,0 then held: one press, D+2 after the last edge.
        clr_counts();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        t0 = cyc;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
        check_int("bounce_press_count", n_press, 1);
        check_int("bounce_press_delay", t_press - t0, D + 2);

        // Reset mid-press: outputs clear with no release, fresh press later.
        clr_counts();
        step(1'b1, 1'b0, 1'b0);
        check4("rst_mid", 4'b0000);
        step(1'b0, 1'b0, 1'b1);
        t0 = cyc;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        check_int("rst_no_release", n_rel, 0);
        check_int("rst_repress_delay", t_press - t0, D + 2);

        // Randomized runs of stable pin levels with occasional resets.
        for (int blk = 0; blk < 400; blk++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40)
                                              : $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 299) == 0), lvl, 1'b1);
                n_cmp++;
                if (int'(key_press) + int'(key_release) + int'(key_long) > 1 ||
                    (key_long && !key_level)) begin
                    n_bad++;
                    $display("FAIL strobe_excl cyc=%0d got=%b want=onehot0", cyc, dut_out());
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
